mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Two-requester arbiter that shares one single-port synchronous RAM (DATA_WIDTH x 2**ADDR_WIDTH, registered read data, one-cycle read latency) between two masters.
- Typical masters: port 0 = pipeline data-memory stage, port 1 = debug/loader unit.
- Serialises accesses, drives the RAM control/address/data lines from registers, and returns read data and a completion pulse to the owning requester.

Parameters:
- DATA_WIDTH, 8, RAM word width in bits.
- ADDR_WIDTH, 4, RAM address width in bits (2**ADDR_WIDTH words).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- req0 / req1  in  1  request from requester 0 / 1; held high until matching ack.
- we0 / we1  in  1  1 = write, 0 = read; stable while req high.
- addr0 / addr1  in  ADDR_WIDTH  access address; stable while req high.
- wdata0 / wdata1  in  DATA_WIDTH  write data; stable while req high.
- ack0 / ack1  out  1  one-cycle pulse: request accepted, requester may change inputs.
- done0 / done1  out  1  one-cycle pulse: access complete (read or write).
- rdata0 / rdata1  out  DATA_WIDTH  read data, valid while matching done high; holds last value otherwise.
- mem_addr  out  ADDR_WIDTH  to RAM address.
- mem_we  out  1  to RAM write_enable.
- mem_re  out  1  to RAM read_enable.
- mem_wdata  out  DATA_WIDTH  to RAM data_in.
- mem_rdata  in  DATA_WIDTH  from RAM data_out.
- busy  out  1  high in ACCESS and RESP.

Behaviour:
- All outputs are registered.
- Reset (rst = 0, asynchronous):
  - state = IDLE, owner = 0, rr pointer = 0.
  - All outputs = 0, including rdata0/rdata1 and mem_addr/mem_wdata.
- States: IDLE -> ACCESS -> RESP -> IDLE. Fixed 3-cycle transaction; max throughput one access per 3 cycles.
- IDLE:
  - If no req: stay IDLE.
  - If any req: pick winner, latch owner, drive mem_addr/mem_wdata from winner, go ACCESS.
  - mem_we = winner's we; mem_re = !we.
  - ack of the winner = 1 for the ACCESS cycle.
- ACCESS:
  - mem_we or mem_re high for exactly this one cycle; RAM performs the op on the closing edge.
  - Next state RESP. mem_we/mem_re return to 0.
- RESP:
  - mem_rdata is valid in this cycle.
  - On the closing edge: rdata_owner <= mem_rdata (reads only; writes leave rdata unchanged), done_owner <= 1, next state IDLE.
  - done is high during the following IDLE cycle.
- Non-owner ack/done/rdata are never disturbed.
- Timing example, req0 read rises in cycle 0:
  - cycle 1: ack0 = 1, mem_re = 1, mem_addr = addr0.
  - cycle 3: done0 = 1, rdata0 valid.
- Back-to-back: a req still high in the IDLE cycle where done pulses is arbitrated immediately. A req high after its ack is a new transaction.
- Simultaneous req0 and req1 in IDLE: port 0 wins (fixed priority; see Optional Feature). Loser's req stays pending and is not acked.
- Requests arriving in ACCESS/RESP are ignored until IDLE; requesters must hold them.
- Reset mid-transaction: state forced to IDLE. The in-flight transaction is dropped: no done, mem_we/mem_re deasserted at once. A RAM write is not performed unless its edge preceded the reset.
- Address and data pass through unchanged; no arithmetic or wrap.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined: 1-bit rr pointer = last granted port, updated at each grant. On simultaneous requests the port not equal to the pointer wins, so alternating grants occur under continuous contention. Single requests are granted regardless of the pointer.
- Undefined: fixed priority, port 0 always wins. With both requests held continuously, port 1 starves. No pointer register is present.

Test Plan:
- Reset check: hold rst = 0 with reqs high -> all outputs 0, no ack. Release -> first grant 1 cycle later.
- Single write then read: req0 we0 = 1 addr0 = 4'h3 wdata0 = 8'hA5 -> ack0 cycle 1, mem_we pulse with mem_addr = 3, done0 cycle 3. Then read addr 3 -> done0 with rdata0 = 8'hA5.
- Contention: req0 and req1 both read (addr 1 / addr 2, preloaded 8'h11 / 8'h22) in the same cycle:
  - Fixed priority: port 0 served first (rdata0 = 8'h11), port 1 acked cycle 4, done1 cycle 6 with rdata1 = 8'h22.
  - With ARB_ROUND_ROBIN_EN and pointer = 0: port 1 served first.
- Starvation/alternation: both reqs held high for 12 cycles -> fixed priority gives 4 grants to port 0 and 0 to port 1; round robin gives 2 to each, alternating.
- Reset mid-op: assert rst during ACCESS of a write to addr 5 (old value 8'h00) -> no done0. After release, read addr 5 returns 8'h00 if reset preceded the write edge.
- Isolation: port 1 write in progress -> rdata0 holds its previous value 8'h11, ack0/done0 stay 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester arbiter sharing one single-port synchronous RAM; fixed 3-cycle IDLE/ACCESS/RESP transaction.
// Define ARB_ROUND_ROBIN_EN for round-robin on contention; the default build gives port 0 fixed priority.
module mem_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  ack0,
    output logic                  ack1,
    output logic                  done0,
    output logic                  done1,
    output logic [DATA_WIDTH-1:0] rdata0,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic                  mem_re,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t                state, state_nxt;
    logic                  owner, owner_nxt;
    logic                  op_we, op_we_nxt;
    logic                  win;
    logic                  ack0_nxt, ack1_nxt, done0_nxt, done1_nxt;
    logic [DATA_WIDTH-1:0] rdata0_nxt, rdata1_nxt;
    logic [ADDR_WIDTH-1:0] mem_addr_nxt;
    logic [DATA_WIDTH-1:0] mem_wdata_nxt;
    logic                  mem_we_nxt, mem_re_nxt, busy_nxt;
`ifdef ARB_ROUND_ROBIN_EN
    logic                  rr_ptr, rr_ptr_nxt;
`endif

    always_comb begin
        state_nxt     = state;
        owner_nxt     = owner;
        op_we_nxt     = op_we;
        rdata0_nxt    = rdata0;
        rdata1_nxt    = rdata1;
        mem_addr_nxt  = mem_addr;
        mem_wdata_nxt = mem_wdata;
        ack0_nxt      = 1'b0;
        ack1_nxt      = 1'b0;
        done0_nxt     = 1'b0;
        done1_nxt     = 1'b0;
        mem_we_nxt    = 1'b0;
        mem_re_nxt    = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        rr_ptr_nxt    = rr_ptr;
        // Contention goes to the port that was not granted last
        win           = (req0 && req1) ? ~rr_ptr : req1;
`else
        win           = ~req0;
`endif
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    state_nxt     = ACCESS;
                    owner_nxt     = win;
                    op_we_nxt     = win ? we1 : we0;
                    mem_addr_nxt  = win ? addr1 : addr0;
                    mem_wdata_nxt = win ? wdata1 : wdata0;
                    mem_we_nxt    = op_we_nxt;
                    mem_re_nxt    = ~op_we_nxt;
                    ack0_nxt      = ~win;
                    ack1_nxt      = win;
`ifdef ARB_ROUND_ROBIN_EN
                    rr_ptr_nxt    = win;
`endif
                end
            end
            ACCESS: state_nxt = RESP;
            RESP: begin
                state_nxt = IDLE;
                if (owner) begin
                    done1_nxt = 1'b1;
                    if (!op_we) rdata1_nxt = mem_rdata;
                end else begin
                    done0_nxt = 1'b1;
                    if (!op_we) rdata0_nxt = mem_rdata;
                end
            end
            default: state_nxt = IDLE;
        endcase
        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            owner     <= 1'b0;
            op_we     <= 1'b0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            done0     <= 1'b0;
            done1     <= 1'b0;
            rdata0    <= '0;
            rdata1    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
            busy      <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            rr_ptr    <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            owner     <= owner_nxt;
            op_we     <= op_we_nxt;
            ack0      <= ack0_nxt;
            ack1      <= ack1_nxt;
            done0     <= done0_nxt;
            done1     <= done1_nxt;
            rdata0    <= rdata0_nxt;
            rdata1    <= rdata1_nxt;
            mem_addr  <= mem_addr_nxt;
            mem_wdata <= mem_wdata_nxt;
            mem_we    <= mem_we_nxt;
            mem_re    <= mem_re_nxt;
            busy      <= busy_nxt;
`ifdef ARB_ROUND_ROBIN_EN
            rr_ptr    <= rr_ptr_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: RAM environment plus a transaction-timed reference model.
// Honours ARB_ROUND_ROBIN_EN in the same way as the design.
module tb_mem_arbiter;
    localparam int DW = 8;
    localparam int AW = 4;
    localparam int NW = 2 ** AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0, req1, we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          ack0, ack1, done0, done1;
    logic [DW-1:0] rdata0, rdata1;
    logic [AW-1:0] mem_addr;
    logic          mem_we, mem_re;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          busy;

    int n_tests = 0;
    int n_fail  = 0;

    mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .done0(done0), .done1(done1),
        .rdata0(rdata0), .rdata1(rdata1),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_re(mem_re),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    // Single-port RAM with registered read data
    logic [DW-1:0] ram [NW];
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= ram[mem_addr];
    end

    // Reference model: requester intents, memory image and the timing of the last grant
    logic [DW-1:0] ref_mem [NW];
    logic [1:0]    pend, rep, p_we;
    logic [AW-1:0] p_addr [2];
    logic [DW-1:0] p_wd [2];
    bit            has_g, g_port, g_we, last;
    int            g_cyc, cyc, free_cyc;
    logic [AW-1:0] g_addr;
    logic [DW-1:0] g_wd, rd_val;
    logic [1:0]    ack_e, done_e;
    logic [DW-1:0] rdata_e [2];
    logic [AW-1:0] maddr_e;
    logic [DW-1:0] mwd_e;
    logic          busy_e, mwe_e, mre_e;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ack0"},  32'(ack0), 32'd0);
        check({tag, "_ack1"},  32'(ack1), 32'd0);
        check({tag, "_done0"}, 32'(done0), 32'd0);
        check({tag, "_done1"}, 32'(done1), 32'd0);
        check({tag, "_rdata0"}, 32'(rdata0), 32'd0);
        check({tag, "_rdata1"}, 32'(rdata1), 32'd0);
        check({tag, "_maddr"}, 32'(mem_addr), 32'd0);
        check({tag, "_mwdata"}, 32'(mem_wdata), 32'd0);
        check({tag, "_mwe"},   32'(mem_we), 32'd0);
        check({tag, "_mre"},   32'(mem_re), 32'd0);
        check({tag, "_busy"},  32'(busy), 32'd0);
    endtask

    task automatic drive_inputs();
        req0 = pend[0]; we0 = p_we[0]; addr0 = p_addr[0]; wdata0 = p_wd[0];
        req1 = pend[1]; we1 = p_we[1]; addr1 = p_addr[1]; wdata1 = p_wd[1];
    endtask

    task automatic issue(input int p, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        pend[p] = 1'b1; p_we[p] = we; p_addr[p] = a; p_wd[p] = d;
    endtask

    // Advance one cycle and compare every output with the model's expectation for it
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        ack_e  = '0;
        done_e = '0;
        if (has_g && cyc == g_cyc + 2) begin
            if (g_we) ref_mem[g_addr] = g_wd;
            else      rd_val = ref_mem[g_addr];
        end
        if (has_g && cyc == g_cyc + 1) ack_e[g_port] = 1'b1;
        if (has_g && cyc == g_cyc + 3) begin
            done_e[g_port] = 1'b1;
            if (!g_we) rdata_e[g_port] = rd_val;
        end
        busy_e = has_g && (cyc == g_cyc + 1 || cyc == g_cyc + 2);
        mwe_e  = has_g && cyc == g_cyc + 1 && g_we;
        mre_e  = has_g && cyc == g_cyc + 1 && !g_we;
        check("ack0",   32'(ack0),   32'(ack_e[0]));
        check("ack1",   32'(ack1),   32'(ack_e[1]));
        check("done0",  32'(done0),  32'(done_e[0]));
        check("done1",  32'(done1),  32'(done_e[1]));
        check("rdata0", 32'(rdata0), 32'(rdata_e[0]));
        check("rdata1", 32'(rdata1), 32'(rdata_e[1]));
        check("maddr",  32'(mem_addr),  32'(maddr_e));
        check("mwdata", 32'(mem_wdata), 32'(mwd_e));
        check("mwe",    32'(mem_we), 32'(mwe_e));
        check("mre",    32'(mem_re), 32'(mre_e));
        check("busy",   32'(busy),   32'(busy_e));
    endtask

    // Requesters react to this cycle's ack, then the model arbitrates for the closing edge
    task automatic plan(input bit rnd);
        bit w;
        for (int p = 0; p < 2; p++) begin
            if (ack_e[p] && !rep[p]) pend[p] = 1'b0;
            if (rnd && !pend[p] && $urandom_range(2) == 0) begin
                pend[p]   = 1'b1;
                p_we[p]   = 1'($urandom_range(1));
                p_addr[p] = AW'($urandom);
                p_wd[p]   = DW'($urandom);
            end
        end
        drive_inputs();
        if (cyc >= free_cyc && pend != 2'b00) begin
`ifdef ARB_ROUND_ROBIN_EN
            if (pend == 2'b11) w = !last;
            else               w = pend[1];
`else
            w = !pend[0];
`endif
            has_g    = 1'b1;
            g_cyc    = cyc;
            g_port   = w;
            g_we     = p_we[w];
            g_addr   = p_addr[w];
            g_wd     = p_wd[w];
            maddr_e  = g_addr;
            mwd_e    = g_wd;
            free_cyc = cyc + 3;
            last     = w;
        end
    endtask

    task automatic run(input int n, input bit rnd);
        repeat (n) begin
            tick();
            plan(rnd);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        drive_inputs();
        #1;
        check_zero("rst_async");
        repeat (2) begin
            @(posedge clk);
            #1;
            check_zero("rst_hold");
        end
        has_g      = 1'b0;
        ack_e      = '0;
        done_e     = '0;
        rdata_e[0] = '0;
        rdata_e[1] = '0;
        maddr_e    = '0;
        mwd_e      = '0;
        free_cyc   = cyc;
        last       = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        plan(1'b0);
    endtask

    initial begin
        int c0, c1;
        bit found;
        rst = 1'b1;
        pend = '0; rep = '0; p_we = '0;
        p_addr[0] = '0; p_addr[1] = '0; p_wd[0] = '0; p_wd[1] = '0;
        drive_inputs();
        for (int i = 0; i < NW; i++) begin
            ram[i] = '0;
            ref_mem[i] = '0;
        end
        ram[1] = 8'h11; ref_mem[1] = 8'h11;
        ram[2] = 8'h22; ref_mem[2] = 8'h22;
        cyc = 0;
        #2;

        // Reset held with a write pending, then write A5 to 3 and read it back
        issue(0, 1'b1, 4'h3, 8'hA5);
        do_reset();
        run(4, 1'b0);
        issue(0, 1'b0, 4'h3, 8'h00);
        run(6, 1'b0);
        check("rd_a5", 32'(rdata0), 32'h0000_00A5);

        // Simultaneous reads of addresses 1 and 2
        issue(0, 1'b0, 4'h1, 8'h00);
        issue(1, 1'b0, 4'h2, 8'h00);
        run(10, 1'b0);
        check("cont_rdata0", 32'(rdata0), 32'h0000_0011);
        check("cont_rdata1", 32'(rdata1), 32'h0000_0022);

        // Both requests held continuously for 12 cycles
        rep = 2'b11;
        issue(0, 1'b0, 4'h1, 8'h00);
        issue(1, 1'b0, 4'h2, 8'h00);
        c0 = 0;
        c1 = 0;
        repeat (13) begin
            tick();
            if (ack0 === 1'b1) c0++;
            if (ack1 === 1'b1) c1++;
            plan(1'b0);
        end
        rep = 2'b00;
`ifdef ARB_ROUND_ROBIN_EN
        check("grants0", 32'(c0), 32'd2);
        check("grants1", 32'(c1), 32'd2);
`else
        check("grants0", 32'(c0), 32'd4);
        check("grants1", 32'(c1), 32'd0);
`endif
        run(12, 1'b0);

        // Reset during the ACCESS cycle of a write to 5 drops it
        issue(0, 1'b1, 4'h5, 8'h5A);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            plan(1'b0);
            found = (ack0 === 1'b1);
        end
        check("midop_ack_seen", 32'(found), 32'd1);
        #2;
        do_reset();
        run(4, 1'b0);
        issue(0, 1'b0, 4'h5, 8'h00);
        run(6, 1'b0);
        check("midop_rd5", 32'(rdata0), 32'd0);

        // Port 1 write must leave port 0's outputs alone
        issue(0, 1'b0, 4'h1, 8'h00);
        run(6, 1'b0);
        issue(1, 1'b1, 4'h9, 8'h3C);
        run(6, 1'b0);
        check("iso_rdata0", 32'(rdata0), 32'h0000_0011);

        run(400, 1'b1);
        pend = '0;
        run(6, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
